ntt_skew_buffer: RTL and testbench

- Parametrised staggered transpose buffer between NTT memory and the butterfly array. It generalises the fixed 4-lane buffer to NUM_LANES lanes.
- Lane k is a shift register of depth NUM_LANES+k. Reading lane k once NUM_LANES+k words have been written returns that lane's first NUM_LANES coefficients.
- Adds a saturating fill tracker, per-read validity, an underflow error pulse and an optional registered output stage.
- Used in ct mode to gather memory reads before bf2x2, and in gs mode to gather bf2x2 outputs before memory writes.

---
 rtl/ntt_skew_buffer.sv | 171 +++++++++++++++++
 tb/tb_ntt_skew_buffer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_skew_buffer.sv
// ----------------------------------------------------------------------------
// ntt_skew_buffer
//
// Staggered transpose buffer between NTT memory and the butterfly array.
// Lane k is a shift register of depth NUM_LANES+k. Every write shifts all
// lanes toward index 0 and inserts lane k of data_i at the top. Once a lane
// has seen NUM_LANES+k writes, its entries [NUM_LANES-1:0] are that lane's
// first NUM_LANES coefficients. A read presents those entries for the lane
// selected by the read pointer.
//
// Parameters:
//   REG_SIZE   coefficient width in bits
//   NUM_LANES  lanes per word and group size (power of 2, >= 2)
//
// Ports:
//   clk, reset_n    clock; asynchronous active-low reset
//   zeroize         synchronous clear of all state (highest priority)
//   wren            shift data_i into all lanes
//   rden            consume the lane at the read pointer, advance pointer
//   wr_rst_count    clear write group counter and fill tracker
//   rd_rst_count    clear read pointer
//   data_i          one word, lane k in bits [(k+1)*REG_SIZE-1 : k*REG_SIZE]
//   buf0_valid      a group of NUM_LANES writes has just completed
//   data_o          entries [NUM_LANES-1:0] of the selected lane, entry 0 LSB
//   rd_valid        rden asserted and the selected lane is filled
//   rd_err          one-cycle pulse after a read of an unfilled lane
//   wr_fill         saturating write count (max 2*NUM_LANES-1)
//
// Build option:
//   NTT_SKEW_BUF_OREG_EN  when defined, data_o and rd_valid are registered
//                         (one extra cycle of latency). data_o loads only on
//                         rden; rd_valid follows rden & ready every cycle.
// ----------------------------------------------------------------------------
module ntt_skew_buffer #(
    parameter int REG_SIZE  = 23,
    parameter int NUM_LANES = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             zeroize,
    input  logic                             wren,
    input  logic                             rden,
    input  logic                             wr_rst_count,
    input  logic                             rd_rst_count,
    input  logic [NUM_LANES*REG_SIZE-1:0]    data_i,
    output logic                             buf0_valid,
    output logic [NUM_LANES*REG_SIZE-1:0]    data_o,
    output logic                             rd_valid,
    output logic                             rd_err,
    output logic [$clog2(2*NUM_LANES)-1:0]   wr_fill
);

    localparam int WORD_W = NUM_LANES * REG_SIZE;
    localparam int PTR_W  = $clog2(NUM_LANES);
    localparam int FILL_W = $clog2(2 * NUM_LANES);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(2 * NUM_LANES - 1);
    localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_LANES - 1);

    logic [PTR_W-1:0]                   wr_idx;
    logic [PTR_W-1:0]                   wr_idx_reg;
    logic [PTR_W-1:0]                   rd_ptr;
    logic [NUM_LANES-1:0][WORD_W-1:0]   lane_heads;
    logic [NUM_LANES-1:0]               lane_ready;
    logic [WORD_W-1:0]                  sel_word;
    logic                               sel_ready;

    // ------------------------------------------------------------------------
    // Lane shift registers
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        localparam int DEPTH = NUM_LANES + k;
        localparam logic [FILL_W-1:0] READY_AT = FILL_W'(NUM_LANES + k);

        logic [REG_SIZE-1:0] sr [DEPTH];

        // NOTE: the lane storage is reset, not left uninitialised, because
        // data_o is read straight from it and must show 0 after reset/zeroize.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (zeroize) begin
                for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
            end else if (wren) begin
                // NOTE: non-blocking assignments make every stage read the
                // pre-shift value, so the loop order does not matter.
                for (int i = 0; i < DEPTH - 1; i++) sr[i] <= sr[i+1];
                sr[DEPTH-1] <= data_i[k*REG_SIZE +: REG_SIZE];
            end
        end

        // Only the bottom NUM_LANES entries are ever presented on data_o.
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_head
            assign lane_heads[k][i*REG_SIZE +: REG_SIZE] = sr[i];
        end

        assign lane_ready[k] = (wr_fill >= READY_AT);
    end

    assign sel_word  = lane_heads[rd_ptr];
    assign sel_ready = lane_ready[rd_ptr];

    // ------------------------------------------------------------------------
    // Write-side counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx     <= '0;
            wr_idx_reg <= '0;
            wr_fill    <= '0;
        end else if (zeroize || wr_rst_count) begin
            wr_idx     <= '0;
            wr_idx_reg <= '0;
            wr_fill    <= '0;
        end else if (wren) begin
            // NUM_LANES is a power of 2, so natural wrap gives mod NUM_LANES.
            wr_idx     <= wr_idx + PTR_W'(1);
            wr_idx_reg <= wr_idx;
            if (wr_fill != FILL_MAX) wr_fill <= wr_fill + FILL_W'(1);
        end
    end

    // Rises once the last slot of a group has been written, holds until the
    // next write captures a different group index.
    assign buf0_valid = (wr_idx_reg == LAST_IDX);

    // ------------------------------------------------------------------------
    // Read side: pointer and underflow pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            rd_err <= 1'b0;
        end else if (zeroize) begin
            rd_ptr <= '0;
            rd_err <= 1'b0;
        end else begin
            // An underflowing read still consumes its slot.
            if (rd_rst_count)  rd_ptr <= '0;
            else if (rden)     rd_ptr <= rd_ptr + PTR_W'(1);
            rd_err <= rden & ~sel_ready;
        end
    end

    // ------------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------------
`ifdef NTT_SKEW_BUF_OREG_EN
    logic [WORD_W-1:0] data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else if (zeroize) begin
            data_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (rden) data_q <= sel_word;
            rd_valid_q <= rden & sel_ready;
        end
    end

    assign data_o   = data_q;
    assign rd_valid = rd_valid_q;
`else
    assign data_o   = sel_word;
    assign rd_valid = rden & sel_ready;
`endif

endmodule

// File: tb/tb_ntt_skew_buffer.sv
// ----------------------------------------------------------------------------
// tb_ntt_skew_buffer
//
// Bench for ntt_skew_buffer with NUM_LANES=4, REG_SIZE=23, output register
// option off. The reference model remembers the most recent words written
// since the last clear and derives each lane's contents from "the word
// written N writes ago"; counters are kept as plain integers. A compare
// process checks every output against the model on each falling edge, and
// directed sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ntt_skew_buffer;

    localparam int RS     = 23;
    localparam int N      = 4;
    localparam int WORD_W = N * RS;
    localparam int FILL_W = $clog2(2 * N);

    logic              clk = 1'b0;
    logic              reset_n;
    logic              zeroize;
    logic              wren;
    logic              rden;
    logic              wr_rst_count;
    logic              rd_rst_count;
    logic [WORD_W-1:0] data_i;
    logic              buf0_valid;
    logic [WORD_W-1:0] data_o;
    logic              rd_valid;
    logic              rd_err;
    logic [FILL_W-1:0] wr_fill;

    ntt_skew_buffer #(.REG_SIZE(RS), .NUM_LANES(N)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .zeroize      (zeroize),
        .wren         (wren),
        .rden         (rden),
        .wr_rst_count (wr_rst_count),
        .rd_rst_count (rd_rst_count),
        .data_i       (data_i),
        .buf0_valid   (buf0_valid),
        .data_o       (data_o),
        .rd_valid     (rd_valid),
        .rd_err       (rd_err),
        .wr_fill      (wr_fill)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [WORD_W-1:0] wq[$];   // words written since last lane clear, oldest first
    int                m_w;     // writes since last counter clear
    int                m_rp;    // read pointer
    bit                m_err;
    bit                chk_en = 1'b0;

    function automatic int m_fill();
        return (m_w > 2 * N - 1) ? 2 * N - 1 : m_w;
    endfunction

    function automatic bit m_ready(input int k);
        return m_fill() >= N + k;
    endfunction

    // Entry i of lane k (depth N+k) holds the word written (N+k-i) writes ago.
    function automatic logic [RS-1:0] m_entry(input int k, input int i);
        int idx;
        logic [WORD_W-1:0] w;
        idx = wq.size() - (N + k) + i;
        if (idx < 0) return '0;
        w = wq[idx];
        return w[k*RS +: RS];
    endfunction

    function automatic logic [WORD_W-1:0] m_data();
        logic [WORD_W-1:0] r;
        for (int i = 0; i < N; i++) r[i*RS +: RS] = m_entry(m_rp, i);
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wq.delete();
            m_w = 0; m_rp = 0; m_err = 1'b0;
        end else if (zeroize) begin
            wq.delete();
            m_w = 0; m_rp = 0; m_err = 1'b0;
        end else begin
            m_err = rden && !m_ready(m_rp);
            if (wren) begin
                wq.push_back(data_i);
                if (wq.size() > 2 * N) void'(wq.pop_front());
            end
            if (wr_rst_count) m_w = 0;
            else if (wren) m_w++;
            if (rd_rst_count) m_rp = 0;
            else if (rden) m_rp = (m_rp + 1) % N;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_data_o",     data_o,     m_data());
            check("cmp_rd_valid",   rd_valid,   rden && m_ready(m_rp));
            check("cmp_rd_err",     rd_err,     m_err);
            check("cmp_wr_fill",    wr_fill,    m_fill());
            check("cmp_buf0_valid", buf0_valid, (m_w > 0) && (m_w % N == 0));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    function automatic logic [WORD_W-1:0] mk(input int t);
        logic [WORD_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*RS +: RS] = RS'(16 * k + t);
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] lane_group(input int k);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < N; i++) r[i*RS +: RS] = RS'(16 * k + i);
        return r;
    endfunction

    // Drive one cycle's inputs just after the rising edge, return at the
    // falling edge so the caller can sample that cycle's outputs.
    task automatic cyc(input bit we, input bit re, input bit wrc, input bit rrc,
                       input bit zz, input logic [WORD_W-1:0] d);
        @(posedge clk);
        #1;
        wren = we; rden = re; wr_rst_count = wrc; rd_rst_count = rrc;
        zeroize = zz; data_i = d;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, '0);
    endtask

    logic [WORD_W-1:0] rnd;

    initial begin
        reset_n = 1'b0; zeroize = 0; wren = 0; rden = 0;
        wr_rst_count = 0; rd_rst_count = 0; data_i = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_wr_fill", wr_fill, 0);
        check("rst_buf0",    buf0_valid, 0);
        check("rst_data_o",  data_o, 0);
        check("rst_rd_err",  rd_err, 0);

        // Skew transpose
        for (int t = 0; t < 8; t++) begin
            cyc(t <= 6, t >= 4, 0, 0, 0, mk(t));
            if (t >= 4) begin
                check($sformatf("skew_data_k%0d", t - 4), data_o, lane_group(t - 4));
                check($sformatf("skew_valid_k%0d", t - 4), rd_valid, 1);
            end
        end

        // buf0_valid grouping
        cyc(0, 0, 0, 0, 1, '0);
        for (int t = 0; t < 4; t++) cyc(1, 0, 0, 0, 0, mk(t));
        idle(); check("buf0_after4", buf0_valid, 1);
        idle(); check("buf0_hold",   buf0_valid, 1);
        cyc(1, 0, 0, 0, 0, mk(4));
        idle(); check("buf0_drop5",  buf0_valid, 0);
        for (int t = 5; t < 8; t++) cyc(1, 0, 0, 0, 0, mk(t));
        idle(); check("buf0_after8", buf0_valid, 1);

        // Underflow
        cyc(0, 0, 0, 0, 1, '0);
        for (int t = 0; t < 2; t++) cyc(1, 0, 0, 0, 0, mk(t));
        cyc(0, 1, 0, 0, 0, '0);
        check("uf_rd_valid", rd_valid, 0);
        check("uf_err_same", rd_err, 0);
        idle(); check("uf_err_pulse", rd_err, 1);
        idle(); check("uf_err_clear", rd_err, 0);
        for (int t = 2; t < 5; t++) cyc(1, 0, 0, 0, 0, mk(t));
        cyc(0, 1, 0, 0, 0, '0);
        check("uf_ptr1_valid", rd_valid, 1);
        check("uf_ptr1_data",  data_o, lane_group(1));

        // Saturation and pointer wrap
        cyc(0, 0, 0, 0, 1, '0);
        for (int t = 0; t < 20; t++) cyc(1, 0, 0, 0, 0, mk(t));
        idle(); check("sat_fill", wr_fill, 7);
        for (int r = 0; r < 5; r++) begin
            cyc(0, 1, 0, 0, 0, '0);
            check($sformatf("wrap_valid_%0d", r), rd_valid, 1);
        end

        // wr_rst_count with wren: counters clear, lanes still shift
        cyc(1, 0, 1, 1, 0, mk(100));
        idle();
        check("wrc_fill", wr_fill, 0);
        check("wrc_buf0", buf0_valid, 0);
        check("wrc_shift", data_o[3*RS +: RS], 100);

        // zeroize mid-sequence
        for (int t = 0; t < 3; t++) cyc(1, 0, 0, 0, 0, mk(200 + t));
        cyc(1, 1, 0, 0, 1, mk(250));
        idle();
        check("zz_data_o", data_o, 0);
        check("zz_fill",   wr_fill, 0);
        check("zz_buf0",   buf0_valid, 0);
        check("zz_rd_err", rd_err, 0);

        // Asynchronous reset mid-cycle
        for (int t = 0; t < 5; t++) cyc(1, 0, 0, 0, 0, mk(300 + t));
        idle();
        #2 reset_n = 1'b0;
        #1;
        check("arst_data_o", data_o, 0);
        check("arst_fill",   wr_fill, 0);
        check("arst_buf0",   buf0_valid, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) rnd[k*RS +: RS] = RS'($urandom);
            cyc(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 50) == 0,
                ($urandom % 50) == 0, ($urandom % 200) == 0, rnd);
        end

        idle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
